test_yig_unit: RTL and testbench

Registered 8-input, 4-output logic block: samples eight single-bit primary inputs and drives a 4-bit result equal to the number of inputs that are high (population count, 0..8). It is the device under test of the exhaustive-sweep bench. The bench drives an incrementing 8-bit input vector every clock and logs the four outputs each cycle. The block is a small synchronous datapath: an input register, a full-adder compression tree, and an output register.

---
 rtl/test_yig_unit.sv | 67 ++++++
 tb/tb_test_yig_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/test_yig_unit.sv
// Registered 8-input population counter: input register, full-adder
// compression tree, output register. Two-cycle latency, one vector per cycle.
module test_yig_unit (
  input  logic clk,
  input  logic rst_n,
  input  logic pi0,
  input  logic pi1,
  input  logic pi2,
  input  logic pi3,
  input  logic pi4,
  input  logic pi5,
  input  logic pi6,
  input  logic pi7,
  output logic po0,
  output logic po1,
  output logic po2,
  output logic po3
);

  logic [7:0] in_q;
  logic [3:0] out_q;
  logic [3:0] count;

  // {carry, sum} of three equal-weight bits.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  function automatic logic [1:0] half_add(input logic a, input logic b);
    half_add = {a & b, a ^ b};
  endfunction

  logic [1:0] fa_lo, fa_mid, ha_hi;
  logic [1:0] fa_w1, fa_w2, ha_w2, ha_w4;

  always_comb begin
    // Stage A: three weight-1 sums and three weight-2 carries.
    fa_lo  = full_add(in_q[0], in_q[1], in_q[2]);
    fa_mid = full_add(in_q[3], in_q[4], in_q[5]);
    ha_hi  = half_add(in_q[6], in_q[7]);

    // Stage B: collapse weight-1 bits, then the three stage-A carries.
    fa_w1  = full_add(fa_lo[0], fa_mid[0], ha_hi[0]);
    fa_w2  = full_add(fa_lo[1], fa_mid[1], ha_hi[1]);

    // Final ripple: weight-2 pair, then the weight-4 pair.
    ha_w2  = half_add(fa_w2[0], fa_w1[1]);
    ha_w4  = half_add(fa_w2[1], ha_w2[1]);

    count  = {ha_w4[1], ha_w4[0], ha_w2[0], fa_w1[0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, keeping the two stages distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= {pi7, pi6, pi5, pi4, pi3, pi2, pi1, pi0};
      out_q <= count;
    end
  end

  assign {po3, po2, po1, po0} = out_q;

endmodule

// File: tb/tb_test_yig_unit.sv
// Directed bench for test_yig_unit: reset, directed values, full sweep with a
// mid-stream reset, single-bit walk and the register-isolation check.
module tb_test_yig_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pi;
  logic       po0, po1, po2, po3;
  logic [3:0] po;

  int total = 0;
  int bad   = 0;

  test_yig_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pi0   (pi[0]),
    .pi1   (pi[1]),
    .pi2   (pi[2]),
    .pi3   (pi[3]),
    .pi4   (pi[4]),
    .pi5   (pi[5]),
    .pi6   (pi[6]),
    .pi7   (pi[7]),
    .po0   (po0),
    .po1   (po1),
    .po2   (po2),
    .po3   (po3)
  );

  assign po = {po3, po2, po1, po0};

  always #5 clk = ~clk;

  // Directed vectors and the hand-computed value seen after each edge.
  logic [7:0] dir_vec [7] = '{8'h00, 8'h01, 8'h80, 8'h0F, 8'hAA, 8'hFF, 8'hFF};
  logic [3:0] dir_exp [7] = '{4'd8,  4'd0,  4'd1,  4'd1,  4'd4,  4'd4,  4'd8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] expected);
    total++;
    assert (po === expected)
    else begin
      bad++;
      $error("FAIL %s: po=%0d expected=%0d", tag, po, expected);
    end
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] v;

    // Reset held with all inputs high: outputs stay cleared while clocking.
    rst_n = 1'b0;
    pi    = 8'hFF;
    #1;
    check("reset_async", 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), 4'd0);
    end

    // Release between edges: first edge loads in_q, second shows 8.
    rst_n = 1'b1;
    tick();
    check("release_edge1", 4'd0);
    tick();
    check("release_edge2", 4'd8);

    for (int i = 0; i < 7; i++) begin
      pi = dir_vec[i];
      tick();
      check($sformatf("directed%0d", i), dir_exp[i]);
    end

    // Fresh reset, then sweep 0x00..0xFF with a reset pulse at 0x7F.
    rst_n = 1'b0;
    pi    = 8'h00;
    #1;
    check("sweep_reset", 4'd0);
    rst_n = 1'b1;
    prev  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v  = 8'(i);
      pi = v;
      tick();
      check($sformatf("sweep%02h", v), 4'($countones(prev)));
      prev = v;
      if (v == 8'h7F) begin
        #2 rst_n = 1'b0;
        #1;
        check("midreset_async", 4'd0);
        #1 rst_n = 1'b1;
        prev = 8'h00;
      end
    end
    pi = 8'h00;
    tick();
    check("wrap_ff", 4'd8);
    tick();
    check("wrap_00", 4'd0);
    prev = 8'h00;

    // Single-bit walk and its complement.
    for (int k = 0; k < 16; k++) begin
      v  = (k < 8) ? (8'h01 << k) : ~(8'h01 << (k - 8));
      pi = v;
      tick();
      check($sformatf("walk%02h_prev%02h", v, prev), (k == 0) ? 4'd0 : (k <= 8) ? 4'd1 : 4'd7);
      prev = v;
    end
    pi = 8'h00;
    tick();
    check("walk_last", 4'd7);

    // Inputs wiggling between edges must not reach po before two edges pass.
    tick();
    check("iso_settle", 4'd0);
    pi = 8'hFF;
    #3;
    check("iso_between_a", 4'd0);
    pi = 8'h0F;
    #2;
    check("iso_between_b", 4'd0);
    tick();
    check("iso_edge1", 4'd0);
    tick();
    check("iso_edge2", 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
